// File: rtl/shared_arb_pkg.sv
// Shared types and constants for the two-pipeline shared resource arbiter.
// Build option: SHARED_ARB_GLOBAL_STALL_EN selects the global-stall variant (see shared_resource_arbiter).
package shared_arb_pkg;

    localparam int DATA_W_DEFAULT = 32;

    localparam logic OWNER_P1 = 1'b0;
    localparam logic OWNER_P2 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/shared_resource_arbiter_if.sv
// Bundle of pipeline-side and resource-side signals around the shared resource arbiter.
// slave = arbiter view, master = pipelines + resource view.
interface shared_resource_arbiter_if
    import shared_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);

    logic [1:0]        req;
    logic [DATA_W-1:0] req_data_1;
    logic [DATA_W-1:0] req_data_2;
    logic              flush_1;
    logic              flush_2;
    logic              res_start;
    logic [DATA_W-1:0] res_operand;
    logic              res_done;
    logic [DATA_W-1:0] res_result;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              stall_1;
    logic              stall_2;

    modport slave (
        input  req, req_data_1, req_data_2, flush_1, flush_2, res_done, res_result,
        output res_start, res_operand, resp_valid, resp_data, stall_1, stall_2
    );

    modport master (
        output req, req_data_1, req_data_2, flush_1, flush_2, res_done, res_result,
        input  res_start, res_operand, resp_valid, resp_data, stall_1, stall_2
    );

endinterface

// File: rtl/shared_resource_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_pick2
    import shared_arb_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  logic       i_last_grant,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    always_comb begin
        o_grant_valid = |i_eligible;
        o_grant_id    = OWNER_P1;
        case (i_eligible)
            2'b01:   o_grant_id = OWNER_P1;
            2'b10:   o_grant_id = OWNER_P2;
            2'b11:   o_grant_id = ~i_last_grant;
            default: o_grant_id = OWNER_P1;
        endcase
    end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter granting one non-pipelined, variable-latency resource to two pipelines.
// Define SHARED_ARB_GLOBAL_STALL_EN to freeze both pipelines while either waits on the resource.
module shared_resource_arbiter
    import shared_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
)(
    input  logic                      clk,
    input  logic                      reset,
    shared_resource_arbiter_if.slave  arb_if
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_discard;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_result;

    logic [1:0]        w_eligible;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_owner_flush;
    logic              w_discard_now;
    logic [1:0]        w_resp_valid;
    logic              w_stall_1_local;
    logic              w_stall_2_local;

    assign w_eligible    = arb_if.req & ~{arb_if.flush_2, arb_if.flush_1};
    assign w_owner_flush = (r_owner == OWNER_P2) ? arb_if.flush_2 : arb_if.flush_1;
    // A flush landing in the same cycle as res_done still discards the result.
    assign w_discard_now = r_discard | w_owner_flush;

    rr_pick2 u_pick (
        .i_eligible    (w_eligible),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ISSUE;
            ISSUE:   w_next_state = BUSY;
            BUSY:    if (arb_if.res_done) w_next_state = w_discard_now ? IDLE : RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWNER_P1;
            r_last_grant <= OWNER_P2;
            r_discard    <= 1'b0;
        end else if (r_state == IDLE && w_grant_valid) begin
            r_owner      <= w_grant_id;
            r_last_grant <= w_grant_id;
            r_discard    <= 1'b0;
        end else if ((r_state == ISSUE || r_state == BUSY) && w_owner_flush) begin
            r_discard    <= 1'b1;
        end
    end

    // Datapath registers carry no reset; the outputs are gated by state instead.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_grant_valid) begin
            r_operand <= (w_grant_id == OWNER_P2) ? arb_if.req_data_2 : arb_if.req_data_1;
        end
        if (r_state == BUSY && arb_if.res_done && !w_discard_now) begin
            r_result <= arb_if.res_result;
        end
    end

    always_comb begin
        w_resp_valid = 2'b00;
        if (r_state == RESP && !w_owner_flush) begin
            w_resp_valid[r_owner] = 1'b1;
        end
        arb_if.res_start   = (r_state == ISSUE);
        arb_if.res_operand = (r_state == ISSUE) ? r_operand : '0;
        arb_if.resp_valid  = w_resp_valid;
        arb_if.resp_data   = (r_state == RESP) ? r_result : '0;
    end

    assign w_stall_1_local = arb_if.req[0] & ~w_resp_valid[0];
    assign w_stall_2_local = arb_if.req[1] & ~w_resp_valid[1];

`ifdef SHARED_ARB_GLOBAL_STALL_EN
    assign arb_if.stall_1 = w_stall_1_local | w_stall_2_local;
    assign arb_if.stall_2 = w_stall_1_local | w_stall_2_local;
`else
    assign arb_if.stall_1 = w_stall_1_local;
    assign arb_if.stall_2 = w_stall_2_local;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: directed scenarios with literal expectations, then random
// pipelines/resource traffic compared every cycle against a cycle-stamped transaction model.
module tb_shared_resource_arbiter;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    shared_resource_arbiter_if #(.DATA_W(DW)) bus ();

    shared_resource_arbiter #(.DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Applied stimulus for the current cycle
    logic [1:0]    t_req;
    logic [DW-1:0] t_d1, t_d2, t_res;
    logic          t_f1, t_f2, t_done, t_rst;

    // Sampled DUT outputs for the current cycle
    logic          s_start, s_st1, s_st2;
    logic [1:0]    s_rv;
    logic [DW-1:0] s_opnd, s_rdata;

    // Transaction model: one operation in flight, described by cycle stamps
    bit            m_op = 0;
    bit            m_own = 0;
    bit            m_last = 1;
    bit            m_disc = 0;
    bit            m_done = 0;
    logic [DW-1:0] m_opnd = '0;
    logic [DW-1:0] m_res = '0;
    int            m_t_issue = -10;
    int            m_t_resp = -10;
    int            done_at = -10;
    logic [1:0]    m_exp_rv = 2'b00;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic       exp_start, in_resp, oflush, l1, l2, e1, e2;
        logic [1:0] erv;
        exp_start = m_op && (cyc == m_t_issue);
        in_resp   = m_op && m_done && (cyc == m_t_resp);
        oflush    = m_own ? t_f2 : t_f1;
        erv       = 2'b00;
        if (in_resp && !oflush) erv[m_own] = 1'b1;
        l1 = t_req[0] & ~erv[0];
        l2 = t_req[1] & ~erv[1];
`ifdef SHARED_ARB_GLOBAL_STALL_EN
        e1 = l1 | l2;
        e2 = l1 | l2;
`else
        e1 = l1;
        e2 = l2;
`endif
        chk("model res_start", {31'd0, s_start}, {31'd0, exp_start});
        if (exp_start) chk("model res_operand", s_opnd, m_opnd);
        chk("model resp_valid", {30'd0, s_rv}, {30'd0, erv});
        if (erv != 2'b00) chk("model resp_data", s_rdata, m_res);
        chk("model stall_1", {31'd0, s_st1}, {31'd0, e1});
        chk("model stall_2", {31'd0, s_st2}, {31'd0, e2});
        m_exp_rv = erv;
    endtask

    task automatic model_update();
        logic [1:0] elig;
        logic       oflush;
        oflush = m_own ? t_f2 : t_f1;
        if (t_rst) begin
            m_op = 0; m_last = 1; m_done = 0; m_disc = 0;
        end else if (!m_op) begin
            elig = t_req & ~{t_f2, t_f1};
            if (elig != 2'b00) begin
                m_own     = (elig == 2'b11) ? ~m_last : elig[1];
                m_opnd    = m_own ? t_d2 : t_d1;
                m_last    = m_own;
                m_op      = 1; m_disc = 0; m_done = 0;
                m_t_issue = cyc + 1;
                done_at   = cyc + 1 + int'($urandom_range(1, 4));
            end
        end else if (cyc == m_t_issue) begin
            if (oflush) m_disc = 1;
        end else if (!m_done) begin
            if (t_done) begin
                if (m_disc || oflush) m_op = 0;
                else begin
                    m_done = 1; m_res = t_res; m_t_resp = cyc + 1;
                end
            end else if (oflush) m_disc = 1;
        end else begin
            m_op = 0;
        end
    endtask

    task automatic step(input logic [1:0] rq, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic fa, input logic fb, input logic dn,
                        input logic [DW-1:0] rs, input logic rr);
        t_req = rq; t_d1 = a; t_d2 = b; t_f1 = fa; t_f2 = fb; t_done = dn; t_res = rs; t_rst = rr;
        bus.req = rq; bus.req_data_1 = a; bus.req_data_2 = b;
        bus.flush_1 = fa; bus.flush_2 = fb; bus.res_done = dn; bus.res_result = rs;
        reset = rr;
        @(negedge clk);
        s_start = bus.res_start; s_opnd = bus.res_operand; s_rv = bus.resp_valid;
        s_rdata = bus.resp_data; s_st1 = bus.stall_1; s_st2 = bus.stall_2;
        model_check();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle_step(input logic [1:0] rq, input logic [DW-1:0] a, input logic [DW-1:0] b);
        step(rq, a, b, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_step();
        step(2'b00, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    bit            p_req[2];
    bit            p_free[2];
    logic [DW-1:0] p_d[2];

    initial begin
        logic gs_exp;
        logic f[2];
        logic rr, dn, busy;
`ifdef SHARED_ARB_GLOBAL_STALL_EN
        gs_exp = 1'b1;
`else
        gs_exp = 1'b0;
`endif
        bus.req = 2'b00; bus.req_data_1 = '0; bus.req_data_2 = '0;
        bus.flush_1 = 1'b0; bus.flush_2 = 1'b0; bus.res_done = 1'b0; bus.res_result = '0;
        @(posedge clk);
        #1;

        // Reset values; stall follows req during reset
        step(2'b01, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        chk("rst stall_1", {31'd0, s_st1}, 32'd1);
        chk("rst res_start", {31'd0, s_start}, 32'd0);
        chk("rst res_operand", s_opnd, 32'd0);
        chk("rst resp_valid", {30'd0, s_rv}, 32'd0);
        chk("rst resp_data", s_rdata, 32'd0);

        // Single request, L=2
        idle_step(2'b01, 32'hAA, 32'h0);
        chk("single stall_1 t", {31'd0, s_st1}, 32'd1);
        chk("single stall_2 t", {31'd0, s_st2}, {31'd0, gs_exp});
        idle_step(2'b01, 32'hAA, 32'h0);
        chk("single res_start t+1", {31'd0, s_start}, 32'd1);
        chk("single operand t+1", s_opnd, 32'hAA);
        idle_step(2'b01, 32'hAA, 32'h0);
        step(2'b01, 32'hAA, 32'h0, 1'b0, 1'b0, 1'b1, 32'h155, 1'b0);
        chk("single stall_1 t+3", {31'd0, s_st1}, 32'd1);
        chk("single resp_valid t+3", {30'd0, s_rv}, 32'd0);
        idle_step(2'b01, 32'hAA, 32'h0);
        chk("single resp_valid t+4", {30'd0, s_rv}, 32'd1);
        chk("single resp_data t+4", s_rdata, 32'h155);
        chk("single stall_1 t+4", {31'd0, s_st1}, 32'd0);
        chk("single stall_2 t+4", {31'd0, s_st2}, 32'd0);
        reset_step();

        // Tie after reset: P1 first, then P2 despite P1 re-requesting
        idle_step(2'b11, 32'h11, 32'h22);
        idle_step(2'b11, 32'h11, 32'h22);
        chk("tie first operand", s_opnd, 32'h11);
        step(2'b11, 32'h11, 32'h22, 1'b0, 1'b0, 1'b1, 32'h111, 1'b0);
        idle_step(2'b11, 32'h11, 32'h22);
        chk("tie first resp_valid", {30'd0, s_rv}, 32'd1);
        chk("tie stall_2 during P1", {31'd0, s_st2}, 32'd1);
        idle_step(2'b11, 32'h33, 32'h22);
        idle_step(2'b11, 32'h33, 32'h22);
        chk("tie second res_start", {31'd0, s_start}, 32'd1);
        chk("tie second operand", s_opnd, 32'h22);
        step(2'b11, 32'h33, 32'h22, 1'b0, 1'b0, 1'b1, 32'h222, 1'b0);
        chk("tie stall_2 before RESP", {31'd0, s_st2}, 32'd1);
        idle_step(2'b11, 32'h33, 32'h22);
        chk("tie second resp_valid", {30'd0, s_rv}, 32'd2);
        chk("tie second resp_data", s_rdata, 32'h222);
        chk("tie stall_2 at RESP", {31'd0, s_st2}, 32'd0);
        reset_step();

        // Owner flush in BUSY discards the result; P1 granted next
        idle_step(2'b10, 32'h0, 32'h77);
        idle_step(2'b10, 32'h0, 32'h77);
        step(2'b11, 32'h5, 32'h77, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        step(2'b01, 32'h5, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
        chk("flush resp_valid at done", {30'd0, s_rv}, 32'd0);
        idle_step(2'b01, 32'h5, 32'h0);
        chk("flush resp_valid after", {30'd0, s_rv}, 32'd0);
        idle_step(2'b01, 32'h5, 32'h0);
        chk("flush next res_start", {31'd0, s_start}, 32'd1);
        chk("flush next operand", s_opnd, 32'h5);
        reset_step();

        // Req+flush in IDLE: no grant; the later P2 request is granted
        step(2'b01, 32'h9, 32'h0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle_step(2'b10, 32'h0, 32'h99);
        chk("reqflush no res_start", {31'd0, s_start}, 32'd0);
        idle_step(2'b10, 32'h0, 32'h99);
        chk("reqflush P2 res_start", {31'd0, s_start}, 32'd1);
        chk("reqflush P2 operand", s_opnd, 32'h99);
        reset_step();

        // Reset during BUSY then a stale completion
        idle_step(2'b01, 32'h42, 32'h0);
        idle_step(2'b01, 32'h42, 32'h0);
        idle_step(2'b01, 32'h42, 32'h0);
        reset_step();
        idle_step(2'b00, 32'h0, 32'h0);
        step(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBAD, 1'b0);
        chk("stale resp_valid", {30'd0, s_rv}, 32'd0);
        idle_step(2'b01, 32'h43, 32'h0);
        chk("stale resp_valid after", {30'd0, s_rv}, 32'd0);
        idle_step(2'b01, 32'h43, 32'h0);
        chk("post-reset res_start", {31'd0, s_start}, 32'd1);
        chk("post-reset operand", s_opnd, 32'h43);
        reset_step();

        // Stall coupling with only P1 requesting, L=1
        idle_step(2'b01, 32'h7, 32'h0);
        chk("gstall stall_2 t", {31'd0, s_st2}, {31'd0, gs_exp});
        idle_step(2'b01, 32'h7, 32'h0);
        step(2'b01, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0);
        chk("gstall stall_2 t+2", {31'd0, s_st2}, {31'd0, gs_exp});
        idle_step(2'b01, 32'h7, 32'h0);
        chk("gstall resp_valid", {30'd0, s_rv}, 32'd1);
        chk("gstall stall_1 release", {31'd0, s_st1}, 32'd0);
        chk("gstall stall_2 release", {31'd0, s_st2}, 32'd0);
        reset_step();

        // Random pipelines and resource against the model
        p_free[0] = 1; p_free[1] = 1; p_req[0] = 0; p_req[1] = 0;
        p_d[0] = '0; p_d[1] = '0;
        for (int n = 0; n < 4000; n++) begin
            rr = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (p_free[i]) begin
                    p_req[i] = ($urandom_range(0, 1) == 1);
                    p_d[i] = $urandom;
                    p_free[i] = 0;
                end else if (!p_req[i] && $urandom_range(0, 3) == 0) begin
                    p_req[i] = 1;
                    p_d[i] = $urandom;
                end
                f[i] = ($urandom_range(0, 15) == 0);
            end
            busy = m_op && (cyc > m_t_issue) && !m_done;
            dn = busy ? (cyc == done_at) : ($urandom_range(0, 7) == 0);
            step({p_req[1], p_req[0]}, p_d[0], p_d[1], f[0], f[1], dn, $urandom, rr);
            for (int i = 0; i < 2; i++) begin
                if (m_exp_rv[i] || f[i] || rr) begin
                    p_free[i] = 1;
                    p_req[i] = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
